// File: rtl/axi_inval_filter_mp.sv
// Multi-port AW snooper that turns accepted write bursts into line-aligned L1 invalidations.
// Per-port AW FIFOs are drained round-robin, one cache line per cycle, through a single requester.
package axi_inval_filter_mp_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_chan_t;

  typedef aw_chan_t ar_chan_t;

  typedef struct packed {
    aw_chan_t    aw;
    logic        aw_valid;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        w_valid;
    logic        b_ready;
    ar_chan_t    ar;
    logic        ar_valid;
    logic        r_ready;
  } req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        ar_ready;
    logic [3:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        r_valid;
  } resp_t;
endpackage

// Generic synchronous FIFO, non-fall-through: a write is readable the cycle after it lands.
// Latency: 1 cycle write-to-read.
// Backpressure: writes are dropped while full; a pop does not free the slot within the same cycle.
module axi_inval_fifo #(
  parameter type         dat_t = logic,
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wr_vld,
  input  dat_t wr_dat,
  output logic full,
  input  logic rd_rdy,
  output dat_t rd_dat,
  output logic empty
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  dat_t            mem [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_wr, do_rd;

  assign full   = (cnt_q == CntW'(Depth));
  assign empty  = (cnt_q == '0);
  assign do_wr  = wr_vld & ~full;
  assign do_rd  = rd_rdy & ~empty;
  assign rd_dat = mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr_q] <= wr_dat;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      if (do_rd) rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// AXI pass-through that queues accepted AW bursts per port and issues one invalidation per touched line.
// Latency: AW handshake at t gives the first invalidation at t+2; one line per cycle, one idle cycle between bursts.
// Backpressure: a full port FIFO stalls that port's AW; inval_ready_i low holds the current request stable.
module axi_inval_filter_mp #(
  parameter int unsigned NumPorts    = 2,
  parameter int unsigned MaxTxns     = 4,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineWidth = 16,
  parameter type         aw_chan_t   = axi_inval_filter_mp_pkg::aw_chan_t,
  parameter type         req_t       = axi_inval_filter_mp_pkg::req_t,
  parameter type         resp_t      = axi_inval_filter_mp_pkg::resp_t
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic                                            en_i,
  input  req_t                                            slv_req_i  [NumPorts],
  output resp_t                                           slv_resp_o [NumPorts],
  output req_t                                            mst_req_o  [NumPorts],
  input  resp_t                                           mst_resp_i [NumPorts],
  output logic [AddrWidth-1:0]                            inval_addr_o,
  output logic [((NumPorts > 1) ? $clog2(NumPorts) : 1)-1:0] inval_port_o,
  output logic                                            inval_valid_o,
  input  logic                                            inval_ready_i,
  output logic                                            busy_o
);
  localparam int PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int NP    = int'(NumPorts);
  localparam int Off   = $clog2(L1LineWidth);
  localparam int LineW = int'(AddrWidth) - Off;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic {Idle, Issue} state_e;

  logic [NumPorts-1:0]  fifo_push, fifo_pop, fifo_full, fifo_empty;
  aw_chan_t             fifo_dat [NumPorts];
  aw_chan_t             head;
  logic                 arb_vld;
  logic [PortW-1:0]     arb_idx, next_rr;
  logic [AddrWidth-1:0] line_base, beat_bytes, burst_bytes, range_lo, range_hi;
  logic [LineW-1:0]     first_line, last_line;
  logic                 unused_bits;

  state_e           state_q;
  logic [PortW-1:0] rr_q, grant_q;
  logic [LineW-1:0] cur_q, last_q;
  logic             valid_q;

  // AW gating depends only on FIFO fullness, never on the invalidation side.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      mst_req_o[p]           = slv_req_i[p];
      mst_req_o[p].aw_valid  = slv_req_i[p].aw_valid & ~fifo_full[p];
      slv_resp_o[p]          = mst_resp_i[p];
      slv_resp_o[p].aw_ready = mst_resp_i[p].aw_ready & ~fifo_full[p];
      fifo_push[p]           = en_i & slv_req_i[p].aw_valid & mst_resp_i[p].aw_ready & ~fifo_full[p];
      fifo_pop[p]            = (state_q == Issue) & inval_ready_i & (cur_q == last_q)
                               & (grant_q == PortW'(p));
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    axi_inval_fifo #(
      .dat_t (aw_chan_t),
      .Depth (MaxTxns)
    ) i_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .wr_vld (fifo_push[p]),
      .wr_dat (slv_req_i[p].aw),
      .full   (fifo_full[p]),
      .rd_rdy (fifo_pop[p]),
      .rd_dat (fifo_dat[p]),
      .empty  (fifo_empty[p])
    );
  end

  always_comb begin
    logic [PortW-1:0] cand;
    cand    = '0;
    arb_vld = 1'b0;
    arb_idx = '0;
    for (int i = 0; i < NP; i++) begin
      cand = PortW'((int'(rr_q) + i) % NP);
      if (!arb_vld && !fifo_empty[cand]) begin
        arb_vld = 1'b1;
        arb_idx = cand;
      end
    end
  end

  assign head = fifo_dat[arb_idx];

  always_comb begin
    line_base   = AddrWidth'(head.addr);
    beat_bytes  = AddrWidth'(1) << head.size;
    burst_bytes = (AddrWidth'(head.len) + AddrWidth'(1)) << head.size;
    range_lo    = line_base;
    range_hi    = line_base + burst_bytes - AddrWidth'(1);
    case (head.burst)
      BurstFixed: range_hi = line_base + beat_bytes - AddrWidth'(1);
      BurstWrap: begin
        range_lo = line_base & ~(burst_bytes - AddrWidth'(1));
        range_hi = range_lo + burst_bytes - AddrWidth'(1);
      end
      default: ;
    endcase
  end

  assign first_line  = range_lo[AddrWidth-1:Off];
  assign last_line   = range_hi[AddrWidth-1:Off];
  assign unused_bits = ^{range_lo[Off-1:0], range_hi[Off-1:0], head};
  assign next_rr     = (grant_q == PortW'(NumPorts - 1)) ? '0 : grant_q + PortW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      rr_q    <= '0;
      grant_q <= '0;
      cur_q   <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        Idle: begin
          if (arb_vld) begin
            grant_q <= arb_idx;
            cur_q   <= first_line;
            last_q  <= last_line;
            valid_q <= 1'b1;
            state_q <= Issue;
          end
        end
        Issue: begin
          if (inval_ready_i) begin
            if (cur_q == last_q) begin
              rr_q    <= next_rr;
              valid_q <= 1'b0;
              state_q <= Idle;
            end else begin
              cur_q <= cur_q + LineW'(1);
            end
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign inval_valid_o = valid_q;
  assign inval_addr_o  = {cur_q, {Off{1'b0}}};
  assign inval_port_o  = grant_q;
  assign busy_o        = ~(&fifo_empty) | (state_q != Idle);
endmodule

// File: tb/tb_axi_inval_filter_mp.sv
// Bench for axi_inval_filter_mp: directed scenarios plus randomized bursts against a queue-based line model.
module tb_axi_inval_filter_mp;
  import axi_inval_filter_mp_pkg::*;

  localparam int NP = 2;
  localparam int MT = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b1;
  req_t        slv_req  [NP];
  resp_t       slv_resp [NP];
  req_t        mst_req  [NP];
  resp_t       mst_resp [NP];
  logic [63:0] inval_addr;
  logic [0:0]  inval_port;
  logic        inval_valid;
  logic        inval_ready = 1'b0;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [63:0] got_addr[$];
  int          got_port[$];
  int          got_cyc[$];
  logic [63:0] exp_addr[$];
  int          exp_port[$];
  aw_chan_t    mq [NP][$];

  axi_inval_filter_mp #(
    .NumPorts(NP), .MaxTxns(MT), .AddrWidth(64), .L1LineWidth(16)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (en_i),
    .slv_req_i     (slv_req),
    .slv_resp_o    (slv_resp),
    .mst_req_o     (mst_req),
    .mst_resp_i    (mst_resp),
    .inval_addr_o  (inval_addr),
    .inval_port_o  (inval_port),
    .inval_valid_o (inval_valid),
    .inval_ready_i (inval_ready),
    .busy_o        (busy)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (inval_valid && inval_ready) begin
      got_addr.push_back(inval_addr);
      got_port.push_back(int'(inval_port));
      got_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_aw();
    for (int p = 0; p < NP; p++) slv_req[p] = '0;
  endtask

  task automatic clear_got();
    got_addr.delete();
    got_port.delete();
    got_cyc.delete();
  endtask

  task automatic set_aw(input int p, input logic [63:0] a, input logic [7:0] l,
                        input logic [2:0] s, input logic [1:0] b);
    slv_req[p].aw.id    = 4'(p);
    slv_req[p].aw.addr  = a;
    slv_req[p].aw.len   = l;
    slv_req[p].aw.size  = s;
    slv_req[p].aw.burst = b;
    slv_req[p].aw_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_aw();
    inval_ready = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic wait_lines(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      #1;
      if (got_addr.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference: byte range from the burst rules, then every 16-byte line it overlaps.
  function automatic void add_expected(input int p, input aw_chan_t aw);
    logic [63:0] bytes, lo, hi, line;
    bytes = (64'(aw.len) + 64'd1) * (64'd1 << aw.size);
    lo = aw.addr;
    hi = aw.addr + bytes - 64'd1;
    if (aw.burst == 2'd0) hi = aw.addr + (64'd1 << aw.size) - 64'd1;
    if (aw.burst == 2'd2) begin
      lo = aw.addr - (aw.addr % bytes);
      hi = lo + bytes - 64'd1;
    end
    line = lo - (lo % 64'd16);
    while (line <= hi) begin
      exp_addr.push_back(line);
      exp_port.push_back(p);
      line = line + 64'd16;
    end
  endfunction

  task automatic test_reset();
    do_reset();
    @(negedge clk_i);
    checks += 5;
    if (inval_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inval_valid); end
    if (inval_addr !== 64'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", inval_addr); end
    if (inval_port !== 1'b0) begin errors++; $display("FAIL reset_port: got %0d want 0", inval_port); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (slv_resp[0].aw_ready !== 1'b1) begin errors++; $display("FAIL reset_aw_ready: got %b want 1", slv_resp[0].aw_ready); end
  endtask

  task automatic test_single_line();
    inval_ready = 1'b1;
    clear_got();
    tick();
    set_aw(0, 64'h1000, 8'd0, 3'd3, 2'd1);
    tick();
    clear_aw();
    @(negedge clk_i);
    checks += 2;
    if (inval_valid !== 1'b0) begin errors++; $display("FAIL single_t1_valid: got %b want 0", inval_valid); end
    if (busy !== 1'b1) begin errors++; $display("FAIL single_t1_busy: got %b want 1", busy); end
    tick();
    @(negedge clk_i);
    checks += 3;
    if (inval_valid !== 1'b1) begin errors++; $display("FAIL single_t2_valid: got %b want 1", inval_valid); end
    if (inval_addr !== 64'h1000) begin errors++; $display("FAIL single_t2_addr: got %h want 1000", inval_addr); end
    if (inval_port !== 1'b0) begin errors++; $display("FAIL single_t2_port: got %0d want 0", inval_port); end
    tick();
    @(negedge clk_i);
    checks += 3;
    if (inval_valid !== 1'b0) begin errors++; $display("FAIL single_t3_valid: got %b want 0", inval_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL single_t3_busy: got %b want 0", busy); end
    if (got_addr.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", got_addr.size()); end
  endtask

  task automatic test_misaligned();
    bit ok;
    inval_ready = 1'b1;
    clear_got();
    tick();
    set_aw(0, 64'h100C, 8'd1, 3'd3, 2'd1);
    tick();
    clear_aw();
    wait_lines(2, 20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL misaligned_count: got %0d want 2", got_addr.size());
    end else begin
      checks += 3;
      if (got_addr[0] !== 64'h1000) begin errors++; $display("FAIL misaligned_a0: got %h want 1000", got_addr[0]); end
      if (got_addr[1] !== 64'h1010) begin errors++; $display("FAIL misaligned_a1: got %h want 1010", got_addr[1]); end
      if (got_cyc[1] - got_cyc[0] != 1) begin errors++; $display("FAIL misaligned_gap: got %0d want 1", got_cyc[1] - got_cyc[0]); end
    end
  endtask

  task automatic test_wrap_fixed();
    bit ok;
    inval_ready = 1'b1;
    clear_got();
    tick();
    set_aw(0, 64'h2018, 8'd3, 3'd3, 2'd2);
    tick();
    clear_aw();
    wait_lines(2, 20, ok);
    repeat (4) tick();
    checks++;
    if (got_addr.size() != 2) begin
      errors++; $display("FAIL wrap_count: got %0d want 2", got_addr.size());
    end else begin
      checks += 2;
      if (got_addr[0] !== 64'h2000) begin errors++; $display("FAIL wrap_a0: got %h want 2000", got_addr[0]); end
      if (got_addr[1] !== 64'h2010) begin errors++; $display("FAIL wrap_a1: got %h want 2010", got_addr[1]); end
    end
    clear_got();
    set_aw(1, 64'h2FFC, 8'd7, 3'd2, 2'd0);
    tick();
    clear_aw();
    wait_lines(1, 20, ok);
    repeat (4) tick();
    checks++;
    if (got_addr.size() != 1) begin
      errors++; $display("FAIL fixed_count: got %0d want 1", got_addr.size());
    end else begin
      checks += 2;
      if (got_addr[0] !== 64'h2FF0) begin errors++; $display("FAIL fixed_a0: got %h want 2ff0", got_addr[0]); end
      if (got_port[0] != 1) begin errors++; $display("FAIL fixed_port: got %0d want 1", got_port[0]); end
    end
  endtask

  task automatic test_arbitration();
    bit ok;
    do_reset();
    inval_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      clear_got();
      tick();
      set_aw(0, 64'h3000, 8'd0, 3'd3, 2'd1);
      set_aw(1, 64'h4000, 8'd0, 3'd3, 2'd1);
      tick();
      clear_aw();
      wait_lines(2, 20, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL arb_count%0d: got %0d want 2", r, got_addr.size());
      end else begin
        checks += 5;
        if (got_addr[0] !== 64'h3000) begin errors++; $display("FAIL arb_a0_%0d: got %h want 3000", r, got_addr[0]); end
        if (got_port[0] != 0) begin errors++; $display("FAIL arb_p0_%0d: got %0d want 0", r, got_port[0]); end
        if (got_addr[1] !== 64'h4000) begin errors++; $display("FAIL arb_a1_%0d: got %h want 4000", r, got_addr[1]); end
        if (got_port[1] != 1) begin errors++; $display("FAIL arb_p1_%0d: got %0d want 1", r, got_port[1]); end
        if (got_cyc[1] - got_cyc[0] != 2) begin errors++; $display("FAIL arb_bubble_%0d: got %0d want 2", r, got_cyc[1] - got_cyc[0]); end
      end
      repeat (3) tick();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    clear_got();
    for (int i = 0; i < MT; i++) begin
      tick();
      set_aw(0, 64'h6000 + 64'(i) * 64'h100, 8'd0, 3'd3, 2'd1);
      @(negedge clk_i);
      checks += 2;
      if (slv_resp[0].aw_ready !== 1'b1) begin errors++; $display("FAIL bp_ready%0d: got %b want 1", i, slv_resp[0].aw_ready); end
      if (mst_req[0].aw_valid !== 1'b1) begin errors++; $display("FAIL bp_dsvalid%0d: got %b want 1", i, mst_req[0].aw_valid); end
    end
    tick();
    set_aw(0, 64'h6400, 8'd0, 3'd3, 2'd1);
    inval_ready = 1'b1;
    @(negedge clk_i);
    checks += 3;
    if (slv_resp[0].aw_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", slv_resp[0].aw_ready); end
    if (mst_req[0].aw_valid !== 1'b0) begin errors++; $display("FAIL bp_full_dsvalid: got %b want 0", mst_req[0].aw_valid); end
    if (inval_valid !== 1'b1) begin errors++; $display("FAIL bp_issue_valid: got %b want 1", inval_valid); end
    tick();
    inval_ready = 1'b0;
    @(negedge clk_i);
    checks++;
    if (slv_resp[0].aw_ready !== 1'b1) begin errors++; $display("FAIL bp_freed_ready: got %b want 1", slv_resp[0].aw_ready); end
    tick();
    clear_aw();
    inval_ready = 1'b1;
    wait_lines(5, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bp_count: got %0d want 5", got_addr.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_addr[i] !== 64'h6000 + 64'(i) * 64'h100) begin
          errors++; $display("FAIL bp_order%0d: got %h want %h", i, got_addr[i], 64'h6000 + 64'(i) * 64'h100);
        end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_en_reset();
    bit ok;
    do_reset();
    en_i = 1'b0;
    inval_ready = 1'b1;
    clear_got();
    tick();
    set_aw(1, 64'h7000, 8'd0, 3'd3, 2'd1);
    @(negedge clk_i);
    checks += 2;
    if (mst_req[1].aw_valid !== 1'b1) begin errors++; $display("FAIL en_dsvalid: got %b want 1", mst_req[1].aw_valid); end
    if (slv_resp[1].aw_ready !== 1'b1) begin errors++; $display("FAIL en_ready: got %b want 1", slv_resp[1].aw_ready); end
    tick();
    clear_aw();
    repeat (5) tick();
    checks += 2;
    if (got_addr.size() != 0) begin errors++; $display("FAIL en_noinval: got %0d want 0", got_addr.size()); end
    if (busy !== 1'b0) begin errors++; $display("FAIL en_busy: got %b want 0", busy); end
    en_i = 1'b1;
    set_aw(0, 64'h9000, 8'd0, 3'd3, 2'd1);
    set_aw(1, 64'h8000, 8'd7, 3'd3, 2'd1);
    tick();
    clear_aw();
    wait_lines(3, 30, ok);
    rst_ni = 1'b0;
    #1;
    checks += 3;
    if (!ok) begin errors++; $display("FAIL rst_pre_count: got %0d want 3", got_addr.size()); end
    if (inval_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", inval_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (10) tick();
    checks++;
    if (got_addr.size() != 3) begin
      errors++; $display("FAIL rst_residual: got %0d want 3", got_addr.size());
    end else begin
      checks += 3;
      if (got_addr[0] !== 64'h9000 || got_port[0] != 0) begin errors++; $display("FAIL rst_l0: got %h/%0d want 9000/0", got_addr[0], got_port[0]); end
      if (got_addr[1] !== 64'h8000 || got_port[1] != 1) begin errors++; $display("FAIL rst_l1: got %h/%0d want 8000/1", got_addr[1], got_port[1]); end
      if (got_addr[2] !== 64'h8010 || got_port[2] != 1) begin errors++; $display("FAIL rst_l2: got %h/%0d want 8010/1", got_addr[2], got_port[2]); end
    end
  endtask

  task automatic test_random();
    int          cnt [NP];
    int          rr_m;
    int          left;
    bit          stall_prev;
    logic [63:0] a_prev;
    logic [0:0]  p_prev;
    aw_chan_t    aw;
    do_reset();
    rr_m = 0;
    for (int round = 0; round < 25; round++) begin
      inval_ready = 1'b0;
      clear_got();
      exp_addr.delete();
      exp_port.delete();
      left = 0;
      for (int p = 0; p < NP; p++) begin
        cnt[p] = $urandom_range(0, MT);
        left += cnt[p];
      end
      for (int j = 0; j < MT; j++) begin
        tick();
        for (int p = 0; p < NP; p++) begin
          if (j < cnt[p]) begin
            aw.id    = 4'($urandom);
            aw.burst = 2'($urandom_range(0, 2));
            aw.size  = 3'($urandom_range(0, 4));
            aw.addr  = {16'($urandom_range(0, 65534)), 16'h0, 32'($urandom)};
            if (aw.burst == 2'd2) begin
              case ($urandom_range(0, 2))
                0: aw.len = 8'd1;
                1: aw.len = 8'd3;
                default: aw.len = 8'd7;
              endcase
              aw.addr = aw.addr & ~((64'd1 << aw.size) - 64'd1);
            end else begin
              aw.len = 8'($urandom_range(0, 7));
            end
            slv_req[p].aw = aw;
            slv_req[p].aw_valid = 1'b1;
            mq[p].push_back(aw);
          end else begin
            slv_req[p].aw_valid = 1'b0;
          end
        end
      end
      tick();
      clear_aw();
      while (left > 0) begin
        for (int k = 0; k < NP; k++) begin
          if (mq[(rr_m + k) % NP].size() > 0) begin
            add_expected((rr_m + k) % NP, mq[(rr_m + k) % NP].pop_front());
            rr_m = ((rr_m + k) % NP + 1) % NP;
            left--;
            break;
          end
        end
      end
      stall_prev = 1'b0;
      a_prev = '0;
      p_prev = '0;
      for (int c = 0; c < 800; c++) begin
        tick();
        inval_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk_i);
        if (stall_prev) begin
          checks++;
          if (inval_valid !== 1'b1 || inval_addr !== a_prev || inval_port !== p_prev) begin
            errors++;
            $display("FAIL rnd_stable r%0d: got %b/%h/%0d want 1/%h/%0d", round, inval_valid, inval_addr, inval_port, a_prev, p_prev);
          end
        end
        stall_prev = inval_valid && !inval_ready;
        a_prev = inval_addr;
        p_prev = inval_port;
        #1;
        if (got_addr.size() >= exp_addr.size() && !busy) break;
      end
      checks++;
      if (got_addr.size() != exp_addr.size()) begin
        errors++; $display("FAIL rnd_count r%0d: got %0d want %0d", round, got_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        checks++;
        if (got_addr[i] !== exp_addr[i] || got_port[i] != exp_port[i]) begin
          errors++;
          $display("FAIL rnd_line r%0d i%0d: got %h/%0d want %h/%0d", round, i, got_addr[i], got_port[i], exp_addr[i], exp_port[i]);
        end
      end
    end
  endtask

  initial begin
    clear_aw();
    for (int p = 0; p < NP; p++) begin
      mst_resp[p] = '0;
      mst_resp[p].aw_ready = 1'b1;
      mst_resp[p].w_ready  = 1'b1;
      mst_resp[p].ar_ready = 1'b1;
    end
    test_reset();
    test_single_line();
    test_misaligned();
    test_wrap_fixed();
    test_arbitration();
    test_backpressure();
    test_en_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
